decode_stage_hz: RTL
====================

# decode_stage_hz

Parametrised decode stage for the in-order RV32 pipeline, sitting between fetch and execute. It owns the integer register file with write-back bypass. It decodes one instruction per cycle into a registered control/operand bundle, and adds what the first-generation decode lacked:
- valid tracking
- downstream stall hold
- load-use interlock with bubble insertion
- illegal-instruction flagging
- RV32E (16-register) support

## Interface
Parameters:
- XLEN, 32: datapath width (only 32 is supported).
- NREGS, 32: architectural register count; 32 selects RV32I, 16 selects RV32E.
- STACK_ADDR, 32'h0000_03FF: reset value of x2.
- BYPASS_EN, 1: when 1, write-back data is forwarded into the read path.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  squash the instruction entering the decode register
- stall_in  in  1  downstream stall; hold the decode register
- fetch_valid  in  1  instr is a real instruction
- instr  in  32  instruction word
- fetch_instr_addr / fetch_instr_addr_plus  in  32  PC / PC+4
- wb_wr_addr  in  5,  wb_wr_data  in  32,  wb_regfile_wr_enable  in  1  write-back port
- hazard_stall  out  1  combinational load-use stall; fetch holds PC/instr
- dec_valid, dec_illegal  out  1  bundle valid / illegal instruction
- decode_instr_addr, decode_instr_addr_plus, rs_data1, rs_data2, decode_imm  out  32
- decode_rd, decode_rs1, decode_rs2  out  5
- decode_alu_op, decode_result_src  out  2
- decode_funct3  out  3
- decode_funct7b5, decode_jump, decode_jal_src, decode_branch, decode_alu_src, decode_lui_auipc, decode_regfile_wr_enable, decode_datamem_wr_enable  out  1

## Operation
Encodings:
- result_src: 00 ALU, 01 MEM, 10 PC+4, 11 LUI/AUIPC.
- alu_op: 00 add, 01 branch compare, 10 funct-decoded.

Per-opcode decode (imm is sign-extended unless noted):

| Opcode | alu_src | imm | Other controls |
|---|---|---|---|
| R_TYPE | 0 | 0 | wr=1, alu_op 10 |
| I_TYPE | 1 | I | wr=1, alu_op 10 |
| LOAD | 1 | I | wr=1, src MEM, alu_op 00 |
| STORE | 1 | S | dmem_wr=1, wr=0 |
| BRANCH | 0 | B | branch=1, jal_src=1, alu_op 01 |
| JAL | — | J | jump=1, jal_src=1, src PC+4, wr=1 |
| JALR | 1 | I | jump=1, jal_src=0, src PC+4, wr=1 |
| LUI | — | {U, 12'b0} | src 11, lui_auipc=0, wr=1 |
| AUIPC | — | {U, 12'b0} | src 11, lui_auipc=1, wr=1 |

Illegal instructions:
- Any other opcode, or any used rd/rs1/rs2 ≥ NREGS, sets dec_illegal=1 with dec_valid=1.
- All write enables (regfile_wr, datamem_wr, jump, branch) are forced to 0.

Bubble: dec_valid=0 with every enable, control and imm field 0.

Register file:
- NREGS×32; x0 always reads 0.
- On reset: x2 = STACK_ADDR, all others 0.
- Write happens when wb_regfile_wr_enable=1 and wb_wr_addr ≠ 0 and wb_wr_addr < NREGS.

Bypass (BYPASS_EN=1):
- A read of rsN forwards wb_wr_data only when wb_regfile_wr_enable=1, wb_wr_addr=rsN and rsN ≠ 0.
- Otherwise the read comes from the array.

Load-use hazard:
- hazard_stall=1 when all of the following hold: dec_valid, decode_result_src=01, decode_rd≠0, and the incoming instruction (fetch_valid) reads a source equal to decode_rd.
- An instruction reads rs1 for all opcodes except JAL/LUI/AUIPC, and reads rs2 for R_TYPE/STORE/BRANCH only.

Update priority each clock edge:
1. reset: bubble, all outputs 0.
2. flush: bubble.
3. stall_in: hold every output, except that rs_data1/rs_data2 are refreshed with wb_wr_data when a qualified write-back matches decode_rs1/decode_rs2. This prevents stale operands during long stalls.
4. hazard_stall: bubble.
5. fetch_valid=0: bubble.
6. otherwise: capture the decode.

hazard_stall is forced to 0 while stall_in=1 or flush=1.

## Timing
- Latency: 1 cycle from instr to the registered bundle.
- hazard_stall is combinational, valid in the same cycle as instr.
- A load-use pair inserts exactly 1 bubble. The dependent instruction is captured on the following edge; by then the load is in execute, and the execute-stage forwarding supplies the data.
- A write-back in the same cycle as decode is visible in rs_data on the next edge (bypass). With BYPASS_EN=0, it is visible one cycle later.
- flush and stall_in asserted together: flush wins.
- Reset mid-stall clears the bubble state and the register file.

## Test plan
- Reset → x2 reads 0x3FF via `addi x5,x2,0`: rs_data1=0x3FF, dec_valid=1, imm=0.
- `lw x6,0(x1)` then `add x7,x6,x3`:
  - hazard_stall=1 for 1 cycle and one bubble (dec_valid=0, wr_en=0).
  - The add is then captured with decode_rs1=6.
- Write-back x4←0xDEADBEEF in the same cycle as decoding `sub x8,x4,x4`: rs_data1=rs_data2=0xDEADBEEF.
- Write-back with enable=0 to x4 while decoding `sub x8,x4,x4`: array value is used (no bypass).
- stall_in held 3 cycles with a write-back to decode_rs1 during the stall: all fields hold, rs_data1 updates to the write-back data.
- Illegal handling:
  - NREGS=16, `add x20,x1,x2`: dec_illegal=1, regfile_wr_enable=0.
  - Opcode 0x7F: same response.
  - flush+stall_in together: bubble.

Source files
------------

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: RV32I/RV32E decode with register file, write-back bypass, load-use interlock.
// Latency: 1 cycle from instr to the registered bundle; hazard_stall is combinational.
// Backpressure: stall_in holds the bundle and only refreshes operands; hazard_stall asks fetch to hold.
// Ports: clk/rstn; flush, stall_in; fetch_valid/instr/PCs in; write-back port in;
//        hazard_stall out; registered decode bundle out (dec_valid, dec_illegal, operands, controls).
module decode_stage_hz #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter logic [XLEN-1:0] STACK_ADDR = 32'h0000_03FF,
  parameter bit              BYPASS_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            stall_in,
  input  logic            fetch_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] fetch_instr_addr,
  input  logic [XLEN-1:0] fetch_instr_addr_plus,
  input  logic [4:0]      wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data,
  input  logic            wb_regfile_wr_enable,
  output logic            hazard_stall,
  output logic            dec_valid,
  output logic            dec_illegal,
  output logic [XLEN-1:0] decode_instr_addr,
  output logic [XLEN-1:0] decode_instr_addr_plus,
  output logic [XLEN-1:0] rs_data1,
  output logic [XLEN-1:0] rs_data2,
  output logic [XLEN-1:0] decode_imm,
  output logic [4:0]      decode_rd,
  output logic [4:0]      decode_rs1,
  output logic [4:0]      decode_rs2,
  output logic [1:0]      decode_alu_op,
  output logic [1:0]      decode_result_src,
  output logic [2:0]      decode_funct3,
  output logic            decode_funct7b5,
  output logic            decode_jump,
  output logic            decode_jal_src,
  output logic            decode_branch,
  output logic            decode_alu_src,
  output logic            decode_lui_auipc,
  output logic            decode_regfile_wr_enable,
  output logic            decode_datamem_wr_enable
);

  localparam int         AW      = (NREGS == 16) ? 4 : 5;
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      alu_op;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            jump;
    logic            jal_src;
    logic            branch;
    logic            alu_src;
    logic            lui_auipc;
    logic            rf_we;
    logic            dm_we;
  } dec_t;

  logic [XLEN-1:0] r_regs [NREGS];
  dec_t            r_dec;
  dec_t            w_dec;
  logic [6:0]      w_op;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_known, w_use_rd, w_use_rs1, w_use_rs2;
  logic            w_reads_rs1, w_reads_rs2;
  logic            w_wb_q;

  assign w_op  = instr[6:0];
  assign w_rd  = instr[11:7];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  // A write-back that actually lands in the array.
  assign w_wb_q = wb_regfile_wr_enable && (wb_wr_addr != 5'd0) && ({1'b0, wb_wr_addr} < NREGS_W);

  // Forwarding does not check the NREGS bound: an out-of-range source is flagged illegal anyway.
  function automatic logic [XLEN-1:0] f_read(input logic [4:0] a);
    if (BYPASS_EN && wb_regfile_wr_enable && (wb_wr_addr == a) && (a != 5'd0))
      return wb_wr_data;
    else if ((a != 5'd0) && ({1'b0, a} < NREGS_W))
      return r_regs[a[AW-1:0]];
    else
      return '0;
  endfunction

  always_comb begin
    w_dec          = '0;
    w_known        = 1'b1;
    w_use_rd       = 1'b0;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.pc       = fetch_instr_addr;
    w_dec.pc_plus  = fetch_instr_addr_plus;
    w_dec.rd       = w_rd;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.funct3   = instr[14:12];
    w_dec.funct7b5 = instr[30];
    w_dec.rs1_data = f_read(w_rs1);
    w_dec.rs2_data = f_read(w_rs2);
    case (w_op)
      OP_R: begin
        w_dec.alu_op = 2'b10; w_dec.rf_we = 1'b1;
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_I: begin
        w_dec.alu_src = 1'b1; w_dec.alu_op = 2'b10; w_dec.rf_we = 1'b1;
        w_dec.imm = {{20{instr[31]}}, instr[31:20]};
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_dec.alu_src = 1'b1; w_dec.rf_we = 1'b1; w_dec.result_src = 2'b01;
        w_dec.imm = {{20{instr[31]}}, instr[31:20]};
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_dec.alu_src = 1'b1; w_dec.dm_we = 1'b1;
        w_dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_dec.branch = 1'b1; w_dec.jal_src = 1'b1; w_dec.alu_op = 2'b01;
        w_dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_dec.jump = 1'b1; w_dec.jal_src = 1'b1; w_dec.result_src = 2'b10; w_dec.rf_we = 1'b1;
        w_dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        w_use_rd = 1'b1;
      end
      OP_JALR: begin
        w_dec.jump = 1'b1; w_dec.alu_src = 1'b1; w_dec.result_src = 2'b10; w_dec.rf_we = 1'b1;
        w_dec.imm = {{20{instr[31]}}, instr[31:20]};
        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_dec.result_src = 2'b11; w_dec.rf_we = 1'b1;
        w_dec.lui_auipc  = (w_op == OP_AUIPC);
        w_dec.imm = {instr[31:12], 12'b0};
        w_use_rd = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
    if (!w_known || (w_use_rd  && ({1'b0, w_rd}  >= NREGS_W))
                 || (w_use_rs1 && ({1'b0, w_rs1} >= NREGS_W))
                 || (w_use_rs2 && ({1'b0, w_rs2} >= NREGS_W))) begin
      w_dec.illegal = 1'b1;
      w_dec.rf_we   = 1'b0;
      w_dec.dm_we   = 1'b0;
      w_dec.jump    = 1'b0;
      w_dec.branch  = 1'b0;
    end
  end

  // Source usage for the interlock; unknown opcodes are treated as reading rs1.
  assign w_reads_rs1 = !((w_op == OP_JAL) || (w_op == OP_LUI) || (w_op == OP_AUIPC));
  assign w_reads_rs2 = (w_op == OP_R) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

  assign hazard_stall = !stall_in && !flush && fetch_valid && r_dec.valid &&
                        (r_dec.result_src == 2'b01) && (r_dec.rd != 5'd0) &&
                        ((w_reads_rs1 && (w_rs1 == r_dec.rd)) || (w_reads_rs2 && (w_rs2 == r_dec.rd)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dec <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= (i == 2) ? STACK_ADDR : '0;
    end else begin
      if (w_wb_q) r_regs[wb_wr_addr[AW-1:0]] <= wb_wr_data;
      if (flush) begin
        r_dec <= '0;
      end else if (stall_in) begin
        // Held instruction keeps tracking write-backs so it never issues stale operands.
        if (w_wb_q && (wb_wr_addr == r_dec.rs1)) r_dec.rs1_data <= wb_wr_data;
        if (w_wb_q && (wb_wr_addr == r_dec.rs2)) r_dec.rs2_data <= wb_wr_data;
      end else if (hazard_stall || !fetch_valid) begin
        r_dec <= '0;
      end else begin
        r_dec <= w_dec;
      end
    end
  end

  assign dec_valid                = r_dec.valid;
  assign dec_illegal              = r_dec.illegal;
  assign decode_instr_addr        = r_dec.pc;
  assign decode_instr_addr_plus   = r_dec.pc_plus;
  assign rs_data1                 = r_dec.rs1_data;
  assign rs_data2                 = r_dec.rs2_data;
  assign decode_imm               = r_dec.imm;
  assign decode_rd                = r_dec.rd;
  assign decode_rs1               = r_dec.rs1;
  assign decode_rs2               = r_dec.rs2;
  assign decode_alu_op            = r_dec.alu_op;
  assign decode_result_src        = r_dec.result_src;
  assign decode_funct3            = r_dec.funct3;
  assign decode_funct7b5          = r_dec.funct7b5;
  assign decode_jump              = r_dec.jump;
  assign decode_jal_src           = r_dec.jal_src;
  assign decode_branch            = r_dec.branch;
  assign decode_alu_src           = r_dec.alu_src;
  assign decode_lui_auipc         = r_dec.lui_auipc;
  assign decode_regfile_wr_enable = r_dec.rf_we;
  assign decode_datamem_wr_enable = r_dec.dm_we;

endmodule
